muldiv_sequencer: RTL and testbench

- Multi-cycle controller for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), placed in the execute stage beside the ALU.
- Accepts one operation from execute and runs a radix-2 iterative multiply or restoring divide.
- Holds the pipeline stalled until the result is ready, then presents the result for one cycle so the execute pipeline register can capture it in place of the ALU result.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_datapath.sv | 128 ++++++++++++
 rtl/muldiv_sequencer.sv | 126 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } muldiv_state_t;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [MD_XLEN-1:0] DIV0_QUOTIENT = {MD_XLEN{1'b1}};
  localparam logic [MD_XLEN-1:0] INT_MIN       = {1'b1, {(MD_XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_datapath.sv
// Operand sign handling, shared product/remainder shift register and final
// sign fix for the multiply/divide sequencer.
// Build option: MULDIV_FAST_MUL_EN replaces the iterative multiply with a
// single-cycle combinational product.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = MD_XLEN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  finish_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] src_a_i,
  input  logic [DATA_WIDTH-1:0] src_b_i,
  output logic                  special_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] ALL_ONES = W'(DIV0_QUOTIENT);
  localparam logic [W-1:0] MIN_NEG  = W'(INT_MIN);

  logic [2:0]     op_q, op_d;
  logic           neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic [W-1:0]   opnd_q, opnd_d, result_q, result_d;
  logic [2*W-1:0] prod_q, prod_d;

  logic           a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [W-1:0]   a_mag, b_mag, load_res, step_res, quo_fix, rem_fix;
  logic [W:0]     rem_sh, diff;
  logic [2*W-1:0] div_next, prod_fix;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod, fast_fix;
`else
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
`endif

  // Decode signedness of the incoming op, form magnitudes and detect the
  // divide cases that finish without iterating.
  always_comb begin
    a_signed  = (op_i == MD_MULH) || (op_i == MD_MULHSU) || (op_i == MD_DIV) || (op_i == MD_REM);
    b_signed  = (op_i == MD_MULH) || (op_i == MD_DIV) || (op_i == MD_REM);
    a_neg     = a_signed & src_a_i[W-1];
    b_neg     = b_signed & src_b_i[W-1];
    a_mag     = a_neg ? -src_a_i : src_a_i;
    b_mag     = b_neg ? -src_b_i : src_b_i;
    div_zero  = op_i[2] & (src_b_i == '0);
    div_ovf   = op_i[2] & ~op_i[0] & (src_a_i == MIN_NEG) & (src_b_i == ALL_ONES);
    special_o = div_zero | div_ovf;
    load_res  = '0;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
    fast_fix  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
    if (!op_i[2]) load_res = (op_i[1:0] == 2'b00) ? fast_fix[W-1:0] : fast_fix[2*W-1:W];
`endif
    if (div_zero)     load_res = op_i[1] ? src_a_i : ALL_ONES;
    else if (div_ovf) load_res = op_i[1] ? '0 : MIN_NEG;
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for
  // divide. For divide the register holds {remainder, dividend/quotient}.
  always_comb begin
`ifndef MULDIV_FAST_MUL_EN
    mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, prod_q[W-1:1]};
`endif
    rem_sh   = {prod_q[2*W-1:W], prod_q[W-1]};
    diff     = rem_sh - {1'b0, opnd_q};
    div_next = {(diff[W] ? rem_sh[W-1:0] : diff[W-1:0]), prod_q[W-2:0], ~diff[W]};

    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    prod_d    = prod_q;
    if (load_i) begin
      op_d      = op_i;
      neg_d     = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      opnd_d    = op_i[2] ? b_mag : a_mag;
      prod_d    = {{W{1'b0}}, (op_i[2] ? a_mag : b_mag)};
    end else if (step_i) begin
`ifdef MULDIV_FAST_MUL_EN
      prod_d = div_next;
`else
      prod_d = op_q[2] ? div_next : mul_next;
`endif
    end
  end

  // Result selection with sign fix, taken from the post-step register value
  // so it is ready on the same edge the FSM enters DONE.
  always_comb begin
    prod_fix = neg_q ? -prod_d : prod_d;
    quo_fix  = neg_q ? -prod_d[W-1:0] : prod_d[W-1:0];
    rem_fix  = neg_rem_q ? -prod_d[2*W-1:W] : prod_d[2*W-1:W];
    if (op_q[2]) step_res = op_q[1] ? rem_fix : quo_fix;
    else         step_res = (op_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
    result_d = result_q;
    if (finish_i) result_d = load_i ? load_res : step_res;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      prod_q    <= '0;
      result_q  <= '0;
    end else begin
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      prod_q    <= prod_d;
      result_q  <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide controller for the execute stage.
// Build option: MULDIV_FAST_MUL_EN gives single-cycle multiplies.
//
// state   | meaning
// IDLE    | waiting for StartE; stall only through the combinational start term
// MUL_RUN | iterative multiply, one shift-add per cycle
// DIV_RUN | restoring divide, one shift-subtract per cycle
// DONE    | DoneMD high for one cycle with ResultMD/RdMD valid
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  StartE,
  input  logic [2:0]            MulDivOpE,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic [ADDR_WIDTH-1:0] RdE,
  input  logic                  FlushE,
  output logic                  StallMD,
  output logic                  DoneMD,
  output logic [DATA_WIDTH-1:0] ResultMD,
  output logic [ADDR_WIDTH-1:0] RdMD
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  muldiv_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [ADDR_WIDTH-1:0] rd_pend_q, rd_pend_d, rd_q, rd_d;
  logic            load, step, finish, special, quick;

  muldiv_datapath #(.DATA_WIDTH(DATA_WIDTH)) u_datapath (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (load),
    .step_i    (step),
    .finish_i  (finish),
    .op_i      (MulDivOpE),
    .src_a_i   (SrcAE),
    .src_b_i   (SrcBE),
    .special_o (special),
    .result_o  (ResultMD)
  );

  // Next-state and strobe decode.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    quick = special | ~MulDivOpE[2];
`else
    quick = special;
`endif
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    rd_pend_d = rd_pend_q;
    rd_d      = rd_q;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (StartE && !FlushE) begin
          load      = 1'b1;
          rd_pend_d = RdE;
          cnt_d     = '0;
          if (quick) begin
            finish  = 1'b1;
            done_d  = 1'b1;
            rd_d    = RdE;
            state_d = DONE;
          end else begin
            state_d = MulDivOpE[2] ? DIV_RUN : MUL_RUN;
          end
        end
      end
`ifdef MULDIV_FAST_MUL_EN
      DIV_RUN: begin
`else
      MUL_RUN, DIV_RUN: begin
`endif
        if (FlushE) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == LAST) begin
            finish  = 1'b1;
            done_d  = 1'b1;
            rd_d    = rd_pend_q;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      rd_pend_q <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      rd_pend_q <= rd_pend_d;
      rd_q      <= rd_d;
    end
  end

  assign StallMD = ((state_q == IDLE) & StartE & ~FlushE) | (state_q == MUL_RUN) | (state_q == DIV_RUN);
  assign DoneMD  = done_q;
  assign RdMD    = rd_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected results,
// a monitor pops and compares on every DoneMD pulse.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset_n, StartE, FlushE;
  logic [2:0]  MulDivOpE;
  logic [31:0] SrcAE, SrcBE;
  logic [4:0]  RdE;
  logic        StallMD, DoneMD;
  logic [31:0] ResultMD;
  logic [4:0]  RdMD;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  muldiv_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .StartE    (StartE),
    .MulDivOpE (MulDivOpE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .RdE       (RdE),
    .FlushE    (FlushE),
    .StallMD   (StallMD),
    .DoneMD    (DoneMD),
    .ResultMD  (ResultMD),
    .RdMD      (RdMD)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each completion against the oldest expectation.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) chk("done_one_cycle", 32'(DoneMD), 32'd0);
        if (DoneMD) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: result %h rd %0d at cycle %0d, expected no completion", ResultMD, RdMD, cyc);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_result"}, ResultMD, e.res);
            chk({e.name, "_rd"}, 32'(RdMD), 32'(e.rd));
            chk({e.name, "_latency_cycle"}, 32'(cyc), 32'(e.cyc));
          end
        end
        prev_done = DoneMD;
      end
    end
  end

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int lat, input int glitch);
    int   stalls, waited;
    exp_t e;
    @(negedge clk);
    StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b; RdE = rd;
    #1;
    stalls = int'(StallMD);
    e.res = exp; e.rd = rd; e.cyc = cyc + lat; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    StartE = 1'b0; SrcAE = '0; SrcBE = '0; RdE = '0;
    waited = 0;
    while (!DoneMD && waited < 80) begin
      if (glitch > 0 && waited == glitch) begin
        StartE = 1'b1; MulDivOpE = MD_MUL; SrcAE = 32'd99; SrcBE = 32'd5; RdE = 5'd31;
      end else begin
        StartE = 1'b0;
      end
      stalls += int'(StallMD);
      @(negedge clk);
      waited++;
    end
    StartE = 1'b0;
    if (!DoneMD) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no DoneMD within 80 cycles, expected one after %0d", nm, lat);
    end else begin
      chk({nm, "_stall_cycles"}, 32'(stalls), 32'(lat));
      chk({nm, "_stall_on_done"}, 32'(StallMD), 32'd0);
    end
  endtask

  task automatic start_only(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
    @(negedge clk);
    StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b; RdE = rd;
    @(negedge clk);
    StartE = 1'b0;
  endtask

  initial begin
    int waited;
    reset_n = 1'b0; StartE = 1'b0; FlushE = 1'b0;
    MulDivOpE = '0; SrcAE = '0; SrcBE = '0; RdE = '0;
    repeat (2) @(negedge clk);
    chk("reset_done", 32'(DoneMD), 32'd0);
    chk("reset_result", ResultMD, 32'd0);
    chk("reset_rd", 32'(RdMD), 32'd0);
    chk("reset_stall", 32'(StallMD), 32'd0);
    StartE = 1'b1;
    #1 chk("stall_comb_start", 32'(StallMD), 32'd1);
    FlushE = 1'b1;
    #1 chk("stall_comb_flush_prio", 32'(StallMD), 32'd0);
    StartE = 1'b0; FlushE = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    run_op("mul_7_m3",      MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, MUL_LAT, 0);
    run_op("mulh_min",      MD_MULH,   32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, MUL_LAT, 0);
    run_op("mulhu_min",     MD_MULHU,  32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000, MUL_LAT, 0);
    run_op("mulhsu_min",    MD_MULHSU, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'hC000_0000, MUL_LAT, 0);
    run_op("div_m7_2",      MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, DIV_LAT, 0);
    run_op("rem_m7_2",      MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, DIV_LAT, 0);
    run_op("divu_ffff_10",  MD_DIVU,   32'hFFFF_FFFF, 32'h0000_0010, 5'd9,  32'h0FFF_FFFF, DIV_LAT, 5);
    run_op("div_5_0",       MD_DIV,    32'h0000_0005, 32'h0000_0000, 5'd10, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_5_0",       MD_REM,    32'h0000_0005, 32'h0000_0000, 5'd11, 32'h0000_0005, 1, 0);
    run_op("div_ovf",       MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",       MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 1, 0);
    run_op("divu_5_0",      MD_DIVU,   32'h0000_0005, 32'h0000_0000, 5'd16, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_5_0",      MD_REMU,   32'h0000_0005, 32'h0000_0000, 5'd17, 32'h0000_0005, 1, 0);

    // Flush a DIV at run cycle 10: no completion, outputs hold.
    start_only(MD_DIV, 32'd100, 32'd7, 5'd20);
    repeat (9) @(negedge clk);
    chk("flush_pre_stall", 32'(StallMD), 32'd1);
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    chk("flush_stall", 32'(StallMD), 32'd0);
    chk("flush_done", 32'(DoneMD), 32'd0);
    chk("flush_result_hold", ResultMD, 32'h0000_0005);
    chk("flush_rd_hold", 32'(RdMD), 32'd17);
    repeat (40) @(negedge clk);
    run_op("mul_after_flush", MD_MUL, 32'd3, 32'd4, 5'd14, 32'd12, MUL_LAT, 0);

    // FlushE wins over StartE in IDLE.
    @(negedge clk);
    StartE = 1'b1; FlushE = 1'b1; MulDivOpE = MD_DIVU; SrcAE = 32'd9; SrcBE = 32'd3; RdE = 5'd21;
    #1 chk("prio_stall_comb", 32'(StallMD), 32'd0);
    @(negedge clk);
    StartE = 1'b0; FlushE = 1'b0;
    chk("prio_stall_next", 32'(StallMD), 32'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a running op.
`ifdef MULDIV_FAST_MUL_EN
    start_only(MD_DIVU, 32'd300, 32'd7, 5'd22);
`else
    start_only(MD_MUL, 32'd3, 32'd4, 5'd22);
`endif
    repeat (5) @(negedge clk);
    chk("rst_pre_stall", 32'(StallMD), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_done", 32'(DoneMD), 32'd0);
    chk("rst_async_result", ResultMD, 32'd0);
    chk("rst_async_rd", 32'(RdMD), 32'd0);
    chk("rst_async_stall", 32'(StallMD), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op("mul_after_reset", MD_MUL, 32'd3, 32'd4, 5'd15, 32'd12, MUL_LAT, 0);

    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
